// File: rtl/uart_byte_sum_core.sv
// -----------------------------------------------------------------------------
// uart_byte_sum_core
//
// Receives a fixed-length frame of NUM_WORDS bytes over a UART (8N1) line.
// It returns one byte over a second UART line: the 8-bit wrap-around sum of
// every byte in the frame. Bytes that arrive while the reply is being sent
// are dropped. Bytes with a bad stop bit are dropped and are not counted.
//
// Ports
//   sysclk        in   system clock, all logic on the rising edge
//   resetn        in   synchronous active-low reset
//   uart_txd_in   in   serial data from the host, idle high, asynchronous
//   uart_rxd_out  out  serial data to the host, idle high, registered
//
// Internal handshakes are single-cycle pulses with no back-pressure:
//   rx_valid  : receiver -> collector, rx_shift holds the byte for that cycle
//   tx_start  : collector -> transmitter. Issued only when the collector moves
//               to SEND. The collector stays in SEND until tx_done, so the
//               transmitter is always idle when a tx_start arrives.
//   tx_done   : transmitter -> collector, pulses at the end of the stop bit
// -----------------------------------------------------------------------------
module uart_byte_sum_core #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int NUM_WORDS    = 3072,
  parameter int DATA_WIDTH   = 8
) (
  input  logic sysclk,
  input  logic resetn,
  input  logic uart_txd_in,
  output logic uart_rxd_out
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam int WORD_W = $clog2(NUM_WORDS + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  IDX_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer: the host line is asynchronous to sysclk.
  // Both flops reset to the idle level so that no false start bit is seen.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge sysclk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_txd_in;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t              rx_state, rx_state_n;
  logic [CNT_W-1:0]       rx_cnt, rx_cnt_n;
  logic [BIT_W-1:0]       rx_idx, rx_idx_n;
  logic [DATA_WIDTH-1:0]  rx_shift, rx_shift_n;
  logic                   rx_valid, rx_valid_n;

  always_ff @(posedge sysclk) begin
    if (!resetn) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      rx_valid <= rx_valid_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_valid_n = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        rx_idx_n = '0;
        if (!rx_sync) rx_state_n = RX_START;
      end
      RX_START: begin
        // Sample the middle of the start bit. A high level here means the
        // line only glitched low, so the receiver returns to idle.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[DATA_WIDTH-1:1]};
          if (rx_idx == IDX_LAST) begin
            rx_state_n = RX_STOP;
          end else begin
            rx_idx_n = rx_idx + BIT_W'(1);
          end
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        // The stop bit is sampled mid-bit and the receiver goes idle at once.
        // A following start bit can therefore be seen without losing a cycle.
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_valid_n = rx_sync;
          rx_state_n = RX_IDLE;
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame collector FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {
    TOP_COLLECT = 1'b0,
    TOP_SEND    = 1'b1
  } top_state_t;

  top_state_t             top_state, top_state_n;
  logic [WORD_W-1:0]      word_cnt, word_cnt_n;
  logic [DATA_WIDTH-1:0]  acc, acc_n;
  logic [DATA_WIDTH-1:0]  result, result_n;
  logic                   tx_start, tx_start_n;
  logic [DATA_WIDTH-1:0]  acc_sum;
  logic                   tx_done;

  // The addition wraps modulo 2**DATA_WIDTH by width truncation.
  assign acc_sum = acc + rx_shift;

  always_ff @(posedge sysclk) begin
    if (!resetn) begin
      top_state <= TOP_COLLECT;
      word_cnt  <= '0;
      acc       <= '0;
      result    <= '0;
      tx_start  <= 1'b0;
    end else begin
      top_state <= top_state_n;
      word_cnt  <= word_cnt_n;
      acc       <= acc_n;
      result    <= result_n;
      tx_start  <= tx_start_n;
    end
  end

  always_comb begin
    top_state_n = top_state;
    word_cnt_n  = word_cnt;
    acc_n       = acc;
    result_n    = result;
    tx_start_n  = 1'b0;
    case (top_state)
      TOP_COLLECT: begin
        if (rx_valid) begin
          if (word_cnt == WORD_LAST) begin
            // The last byte goes straight into the result. The running state
            // is cleared so the next frame starts from zero.
            result_n    = acc_sum;
            acc_n       = '0;
            word_cnt_n  = '0;
            tx_start_n  = 1'b1;
            top_state_n = TOP_SEND;
          end else begin
            acc_n      = acc_sum;
            word_cnt_n = word_cnt + WORD_W'(1);
          end
        end
      end
      TOP_SEND: begin
        // Received bytes are ignored until the reply has left the line.
        if (tx_done) top_state_n = TOP_COLLECT;
      end
      default: top_state_n = TOP_COLLECT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transmitter FSM. The line output is a register, so every bit level
  // changes exactly on a clock edge and lasts CLKS_PER_BIT cycles.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  tx_state_t              tx_state, tx_state_n;
  logic [CNT_W-1:0]       tx_cnt, tx_cnt_n;
  logic [BIT_W-1:0]       tx_idx, tx_idx_n;
  logic [DATA_WIDTH-1:0]  tx_shift, tx_shift_n;
  logic                   tx_line_n;
  logic                   tx_done_n;

  always_ff @(posedge sysclk) begin
    if (!resetn) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_idx       <= '0;
      tx_shift     <= '0;
      uart_rxd_out <= 1'b1;
      tx_done      <= 1'b0;
    end else begin
      tx_state     <= tx_state_n;
      tx_cnt       <= tx_cnt_n;
      tx_idx       <= tx_idx_n;
      tx_shift     <= tx_shift_n;
      uart_rxd_out <= tx_line_n;
      tx_done      <= tx_done_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_line_n  = uart_rxd_out;
    tx_done_n  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_line_n = 1'b1;
        if (tx_start) begin
          tx_line_n  = 1'b0;
          tx_cnt_n   = '0;
          tx_shift_n = result;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_line_n  = tx_shift[0];
          tx_shift_n = {1'b0, tx_shift[DATA_WIDTH-1:1]};
          tx_state_n = TX_DATA;
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_idx == IDX_LAST) begin
            tx_line_n  = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_idx_n   = tx_idx + BIT_W'(1);
            tx_line_n  = tx_shift[0];
            tx_shift_n = {1'b0, tx_shift[DATA_WIDTH-1:1]};
          end
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_done_n  = 1'b1;
          tx_state_n = TX_IDLE;
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_byte_sum_core.sv
// -----------------------------------------------------------------------------
// Bench for uart_byte_sum_core, using a short bit period and a 4-byte frame.
// The host side is driven bit by bit. Replies are decoded by an independent
// line monitor and compared against a queue-based frame-sum model.
// -----------------------------------------------------------------------------
module tb_uart_byte_sum_core;

  localparam int CPB = 16;
  localparam int NW  = 4;
  localparam int DW  = 8;
  // Host start edge to reply start bit: two synchronizer flops, one cycle to
  // leave idle, half a bit, nine full bits to the stop sample, then the
  // collector and transmitter cycles.
  localparam int REPLY_LAT = 9 * CPB + CPB / 2 + 5;

  logic sysclk = 1'b0;
  logic resetn = 1'b0;
  logic uart_txd_in = 1'b1;
  logic uart_rxd_out;

  uart_byte_sum_core #(
    .CLKS_PER_BIT (CPB),
    .NUM_WORDS    (NW),
    .DATA_WIDTH   (DW)
  ) dut (
    .sysclk       (sysclk),
    .resetn       (resetn),
    .uart_txd_in  (uart_txd_in),
    .uart_rxd_out (uart_rxd_out)
  );

  // ---------------- clock / reset ----------------
  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_q[$];   // expected reply bytes
  int            exp_t_q[$]; // expected reply start cycles
  logic [DW-1:0] frame_q[$]; // bytes the model has accepted into the current frame
  logic [DW-1:0] last_model_sum;
  bit            ignore_next = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: an accepted byte joins the frame. A full frame yields its
  // wrap-around sum as one expected reply.
  task automatic model_accept(input logic [DW-1:0] b, input int t0);
    int s;
    frame_q.push_back(b);
    if (frame_q.size() == NW) begin
      s = 0;
      foreach (frame_q[i]) s += int'(frame_q[i]);
      last_model_sum = DW'(s % 256);
      exp_q.push_back(last_model_sum);
      exp_t_q.push_back(t0 + REPLY_LAT);
      frame_q.delete();
    end
  endtask

  // ---------------- driver tasks (each starts and ends 1 time unit after a posedge) ----------------
  task automatic hold_bit(input logic v);
    uart_txd_in = v;
    repeat (CPB) @(posedge sysclk);
    #1;
  endtask

  task automatic send_byte(input logic [DW-1:0] b, input bit stop_ok, input bit counted);
    if (stop_ok && counted) model_accept(b, cyc);
    hold_bit(1'b0);
    for (int i = 0; i < DW; i++) hold_bit(b[i]);
    hold_bit(stop_ok);
    uart_txd_in = 1'b1;
  endtask

  task automatic send_frame(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                            input logic [DW-1:0] b2, input logic [DW-1:0] b3,
                            input logic [DW-1:0] lit, input string name);
    send_byte(b0, 1'b1, 1'b1);
    send_byte(b1, 1'b1, 1'b1);
    send_byte(b2, 1'b1, 1'b1);
    send_byte(b3, 1'b1, 1'b1);
    check(name, last_model_sum, lit);
  endtask

  task automatic idle(input int n);
    uart_txd_in = 1'b1;
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    @(posedge sysclk);
    #1;
    resetn = 1'b1;
    frame_q.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge sysclk);
      #1;
      n++;
    end
    check("replies_drained", exp_q.size(), 0);
    idle(4);
  endtask

  // ---------------- reply monitor / compare process ----------------
  initial begin
    logic          bits [10];
    logic          v;
    logic [DW-1:0] data;
    bit            width_bad;
    int            t_start;
    forever begin
      @(negedge sysclk);
      if (resetn === 1'b1 && uart_rxd_out === 1'b0) begin
        t_start   = cyc;
        width_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
          v = uart_rxd_out;
          for (int j = 1; j < CPB; j++) begin
            @(negedge sysclk);
            if (uart_rxd_out !== v) width_bad = 1'b1;
          end
          bits[k] = v;
          @(negedge sysclk);
        end
        for (int k = 0; k < DW; k++) data[k] = bits[k + 1];
        if (ignore_next) begin
          ignore_next = 1'b0;
        end else if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_reply: got 0x%0h, expected no character (cycle %0d)", data, t_start);
        end else begin
          check("reply_data", data, exp_q.pop_front());
          check("reply_start_cycle", t_start, exp_t_q.pop_front());
          check("reply_start_bit", bits[0], 1'b0);
          check("reply_stop_bit", bits[9], 1'b1);
          check("reply_bit_width_error", width_bad, 1'b0);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int bad;
    int n;

    // Reset state
    resetn = 1'b0;
    repeat (4) @(posedge sysclk);
    #1;
    check("reset_line_high", uart_rxd_out, 1'b1);
    resetn = 1'b1;

    // Idle after reset: the line must stay high with no start bit
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sysclk);
      if (uart_rxd_out !== 1'b1) bad++;
    end
    @(posedge sysclk);
    #1;
    check("idle_low_cycles", bad, 0);

    // Basic frame and accumulator clearing between frames
    send_frame(8'h10, 8'h20, 8'h30, 8'hF5, 8'h55, "model_sum_55");
    drain();
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, "model_sum_0a");
    drain();

    // Wrap-around sums
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, "model_sum_fc");
    drain();
    send_frame(8'h40, 8'h40, 8'h40, 8'h40, 8'h00, "model_sum_00");
    drain();

    // Framing error: the byte with a low stop bit is not counted
    send_byte(8'h80, 1'b0, 1'b0);
    idle(2 * CPB);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, "model_sum_aa");
    drain();

    // Glitch shorter than half a bit is not a character
    uart_txd_in = 1'b0;
    repeat (5) @(posedge sysclk);
    #1;
    idle(2 * CPB);
    send_frame(8'hFF, 8'h02, 8'h03, 8'h04, 8'h08, "model_sum_08");
    drain();

    // A byte that completes while the reply is still on the line is discarded
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, "model_sum_0a_b");
    send_byte(8'h7F, 1'b1, 1'b0);
    send_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A, "model_sum_1a");
    drain();

    // Reset mid-frame drops the partial frame
    send_byte(8'h33, 1'b1, 1'b1);
    send_byte(8'h44, 1'b1, 1'b1);
    idle(3);
    pulse_reset();
    send_frame(8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h2A, "model_sum_2a");
    drain();

    // Reset in the middle of the reply's data bits aborts the character
    send_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E, "model_sum_0e");
    n = 0;
    while (uart_rxd_out !== 1'b0 && n < 400) begin
      @(posedge sysclk);
      #1;
      n++;
    end
    check("abort_reply_started", (n < 400), 1'b1);
    repeat (3 * CPB) @(posedge sysclk);
    #1;
    ignore_next = 1'b1;
    void'(exp_q.pop_front());
    void'(exp_t_q.pop_front());
    pulse_reset();
    check("abort_line_high_next_edge", uart_rxd_out, 1'b1);
    bad = 0;
    for (int i = 0; i < 12 * CPB; i++) begin
      @(negedge sysclk);
      if (uart_rxd_out !== 1'b1) bad++;
    end
    @(posedge sysclk);
    #1;
    check("abort_low_cycles", bad, 0);
    send_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A, "model_sum_1a_b");
    drain();

    idle(3 * CPB);
    check("no_pending_replies", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_byte_sum_core.md
Name: uart_byte_sum_core

Overview:
- Top-level FPGA IP: receives a fixed-length frame of bytes from a host over UART (8N1), reduces the frame to a one-byte result and returns that byte over UART.
- Sits between the board UART pins and the host test harness.
- Result byte = 8-bit modular sum of all frame bytes. This is the stand-in for the classifier output; the UART framing and handshake are final.

Parameters:
- CLKS_PER_BIT, 1250, sysclk cycles per UART bit (2 ns clock, 2500 ns bit).
- NUM_WORDS, 3072, bytes per input frame.
- DATA_WIDTH, 8, UART data bits per character.

Ports:
- sysclk  input  1  system clock, all logic on rising edge.
- resetn  input  1  synchronous active-low reset.
- uart_txd_in  input  1  serial data from host, idle high.
- uart_rxd_out  output  1  serial data to host, idle high.

Interface: one clock; reset is synchronous and active-low. Clock is sysclk, reset is resetn. No other clock domains; uart_txd_in is asynchronous.

Behaviour:
- Reset (resetn low at a rising edge):
  - uart_rxd_out = 1; byte counter = 0; accumulator = 0; top FSM = COLLECT; RX FSM = IDLE; TX FSM = IDLE.
  - Reset mid-frame or mid-transmission aborts the frame or transmission. Line is high from the next edge.
- RX input: uart_txd_in passes through a 2-flop synchronizer before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: synchronized line low -> START, bit counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles (integer division), then sample. Still low -> DATA. High -> glitch, back to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles; DATA_WIDTH bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. Line high -> 1-cycle rx_valid pulse with the byte. Line low -> framing error, byte discarded and not counted. Either way -> IDLE.
  - RX accepts a new start bit right after the stop-bit sample (half-bit early return tolerates back-to-back characters).
- Top FSM states: COLLECT, SEND.
  - COLLECT: on rx_valid, accumulator <= accumulator + byte (mod 256) and counter++. When the accepted byte makes counter == NUM_WORDS, latch the result (including that byte), clear counter and accumulator, go to SEND.
  - SEND: rx_valid pulses are ignored; those bytes are discarded. Return to COLLECT when TX reports done.
- TX FSM states: IDLE, START, DATA, STOP.
  - Each bit is held exactly CLKS_PER_BIT cycles: start 0, DATA_WIDTH bits LSB first, stop 1. Total 10*CLKS_PER_BIT cycles.
  - uart_rxd_out is registered.
  - Start bit is driven exactly 2 sysclk cycles after the rx_valid pulse of the last frame byte.
  - tx_done is raised at the end of the stop-bit period; the line stays high afterwards.
- Frames repeat indefinitely. Each frame's sum starts at 0.
- Arithmetic: 8-bit wrap-around add; no saturation.
- Counter width: clog2(NUM_WORDS+1) bits.

Test Plan:
- Reset then idle, with CLKS_PER_BIT=1250 and NUM_WORDS=3072 -> uart_rxd_out = 1 and no start bit for 100000 cycles.
- Send 3072 bytes 0x01 at 2500 ns/bit -> one reply character 0x00 (3072 mod 256). Start bit begins 2 cycles after the final stop-bit sample; each bit is 1250 cycles wide.
- NUM_WORDS=4, send 0x10, 0x20, 0x30, 0xF5 -> reply 0x55. Then send 0x01, 0x02, 0x03, 0x04 -> reply 0x0A (accumulator cleared between frames).
- NUM_WORDS=2, send 0x80 with stop bit forced low, then 0x01, 0x02 -> reply 0x03 (framing-error byte not counted).
- Low pulse of 100 cycles on uart_txd_in (shorter than half a bit) -> no byte accepted; the following 2-byte frame 0xFF, 0x02 -> reply 0x01.
- Assert resetn low for 1 cycle in the middle of the reply's data bits -> line high on the next edge, no further bits. A new 2-byte frame 0x05, 0x06 -> reply 0x0B.
